// File: rtl/lgn_image_rx.sv
// rtl/lgn_image_rx.sv - LGN image byte receiver with double-buffered 256-bit frame output
// Optional idle-gap pointer resync is enabled by defining LGN_RX_RESYNC_EN.
module lgn_image_rx #(
    parameter int BYTES_PER_FRAME    = 32,
    parameter int COUNT_WIDTH        = 16,
    parameter int IDLE_RESYNC_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic [7:0]                     byte_in,
    input  logic                           we_n,
    input  logic                           frame_ack,
    output logic [8*BYTES_PER_FRAME-1:0]   frame_out,
    output logic                           frame_valid,
    output logic                           frame_pending,
    output logic                           overrun,
    output logic [$clog2(BYTES_PER_FRAME)-1:0] byte_ptr,
    output logic [COUNT_WIDTH-1:0]         frame_count
);

    localparam int FW = 8 * BYTES_PER_FRAME;
    localparam int PW = $clog2(BYTES_PER_FRAME);
    localparam logic [PW-1:0] LAST_SLOT = PW'(BYTES_PER_FRAME - 1);

    logic [FW-1:0] assembly;
    logic [FW-1:0] merged;
    logic          accept;
    logic          complete;
    logic          resync;

    assign accept   = ena && !we_n;
    assign complete = accept && (byte_ptr == LAST_SLOT);

    // Assembly with this cycle's byte already in place, so completion publishes all slots.
    always_comb begin
        merged = assembly;
        merged[8*byte_ptr +: 8] = byte_in;
    end

`ifdef LGN_RX_RESYNC_EN
    localparam int IW = $clog2(IDLE_RESYNC_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_RESYNC_CYCLES);

    logic [IW-1:0] idle_cnt;

    // Fires on the idle cycle that brings the count up to the limit; the counter then saturates.
    assign resync = ena && we_n && (idle_cnt == IDLE_MAX - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (accept) begin
            idle_cnt <= '0;
        end else if (ena && we_n && idle_cnt != IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign resync = 1'b0 & (IDLE_RESYNC_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            assembly      <= '0;
            byte_ptr      <= '0;
            frame_out     <= '0;
            frame_valid   <= 1'b0;
            frame_pending <= 1'b0;
            overrun       <= 1'b0;
            frame_count   <= '0;
        end else begin
            frame_valid <= complete;

            if (resync) begin
                byte_ptr <= '0;
                assembly <= '0;
            end else if (accept) begin
                assembly <= merged;
                byte_ptr <= complete ? '0 : byte_ptr + 1'b1;
            end

            if (complete) begin
                frame_out   <= merged;
                frame_count <= frame_count + 1'b1;
            end

            // Newest frame always wins; overrun only records that one was never acknowledged.
            if (ena) begin
                if (complete) begin
                    frame_pending <= 1'b1;
                    if (frame_pending && !frame_ack) begin
                        overrun <= 1'b1;
                    end
                end else if (frame_ack) begin
                    frame_pending <= 1'b0;
                end
            end
        end
    end

endmodule
